// File: rtl/inst_split_if.sv
// Fetch-to-decode handshake bundle for the store-split sequencer, including the
// combinational side-channel to the companion instruction divider.
interface inst_split_if;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        in_ready;
  logic [31:0] div_src;
  logic [31:0] div_res;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_split;
  logic        out_ready;

  // Environment side: upstream fetch, divider and downstream decode.
  modport master (
    output in_valid, in_inst, in_pc, div_res, out_ready,
    input  in_ready, div_src, out_valid, out_inst, out_pc, out_split
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_inst, in_pc, div_res, out_ready,
    output in_ready, div_src, out_valid, out_inst, out_pc, out_split
  );
endinterface

// File: rtl/inst_split_seq.sv
// Splits sb/sh stores into a generated prefix lw followed by the original store;
// every other instruction passes straight through a single registered decode slot.
module inst_split_seq (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  inst_split_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PRE   = 2'd1,
    ST_ORIG  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_split_q, out_split_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  logic in_ready_s;
  logic accept_s;
  logic split_s;

  function automatic logic is_split_store(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == 7'b0100011) && ((funct3 == 3'b000) || (funct3 == 3'b001));
  endfunction

  assign in_ready_s = !flush && ((state_q == ST_EMPTY) ||
                                 ((state_q == ST_ORIG) && bus.out_ready));
  assign accept_s   = bus.in_valid && in_ready_s;
  assign split_s    = is_split_store(bus.in_inst[6:0], bus.in_inst[14:12]);

  assign bus.in_ready  = in_ready_s;
  assign bus.div_src   = bus.in_inst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_split = out_split_q;

  // Next-state and output-slot update; flush overrides every other event.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_split_d = out_split_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;

    if (flush) begin
      state_d     = ST_EMPTY;
      out_valid_d = 1'b0;
      out_split_d = 1'b0;
      hold_inst_d = 32'h0000_0000;
      hold_pc_d   = 32'h0000_0000;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
      out_pc_d    = bus.in_pc;
      if (split_s) begin
        state_d     = ST_PRE;
        out_inst_d  = bus.div_res;
        out_split_d = 1'b1;
        hold_inst_d = bus.in_inst;
        hold_pc_d   = bus.in_pc;
      end else begin
        state_d     = ST_ORIG;
        out_inst_d  = bus.in_inst;
        out_split_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          state_d = ST_EMPTY;
        end
        ST_PRE: begin
          // Prefix consumed: present the held store under the same PC.
          if (bus.out_ready) begin
            state_d     = ST_ORIG;
            out_inst_d  = hold_inst_q;
            out_pc_d    = hold_pc_q;
            out_split_d = 1'b0;
          end else begin
            state_d = ST_PRE;
          end
        end
        ST_ORIG: begin
          if (bus.out_ready) begin
            state_d     = ST_EMPTY;
            out_valid_d = 1'b0;
          end else begin
            state_d = ST_ORIG;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          out_valid_d = 1'b0;
          out_split_d = 1'b0;
        end
      endcase
    end
  end

  // State, output slot and held store registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0000_0000;
      out_pc_q    <= 32'h0000_0000;
      out_split_q <= 1'b0;
      hold_inst_q <= 32'h0000_0000;
      hold_pc_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_split_q <= out_split_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

endmodule

// File: doc/inst_split_seq.md
INST_SPLIT_SEQ -- requirements
Module: inst_split_seq

Interface
- REQ-001: clk  input  1  single clock; all state updates on rising edge.
- REQ-002: rst_n  input  1  reset, asynchronous, active-low.
- REQ-003: flush  input  1  synchronous kill of all held instructions (branch/trap redirect).
- REQ-004: in_valid  input  1  upstream fetch slot holds an instruction.
- REQ-005: in_inst  input  `WIDTH_INST (32)  fetched instruction.
- REQ-006: in_pc  input  32  PC of in_inst.
- REQ-007: in_ready  output  1  block accepts in_inst this cycle.
- REQ-008: div_src  output  32  operand to the companion instruction-divider (store -> prefix lw generator); equals in_inst combinationally.
- REQ-009: div_res  input  32  divider result for div_src, combinational, same cycle.
- REQ-010: out_valid  output  1  decode slot holds an instruction.
- REQ-011: out_inst  output  32  instruction presented to decode.
- REQ-012: out_pc  output  32  PC of out_inst.
- REQ-013: out_split  output  1  out_inst is a generated prefix lw, not an architectural instruction.
- REQ-014: out_ready  input  1  decode consumes out_inst this cycle.

Function
- REQ-015: split-class = opcode in_inst[6:0]==7'b0100011 and funct3 in_inst[14:12] in {3'b000 (sb), 3'b001 (sh)}; all other encodings, sw included, are pass-through.
- REQ-016: states: EMPTY, PRE (prefix lw held), ORIG (architectural instruction held); encoding free.
- REQ-017: all outputs except in_ready and div_src are registered.
- REQ-018: in_ready = !flush && (state==EMPTY || (state==ORIG && out_ready)).
- REQ-019: accept = in_valid && in_ready.
- REQ-020: accept of split-class: next state PRE; out_inst<=div_res, out_pc<=in_pc, out_split<=1, out_valid<=1; original in_inst and in_pc captured in internal hold registers.
- REQ-021: accept of pass-through: next state ORIG; out_inst<=in_inst, out_pc<=in_pc, out_split<=0, out_valid<=1.
- REQ-022: PRE && out_ready: next state ORIG; out_inst<=held original, out_pc unchanged, out_split<=0; in_ready stays 0 that cycle.
- REQ-023: PRE && !out_ready or ORIG && !out_ready: all outputs hold; out_valid stays 1.
- REQ-024: ORIG && out_ready && !in_valid: next state EMPTY, out_valid<=0; out_inst/out_pc hold stale values.
- REQ-025: ORIG && out_ready && in_valid: back-to-back accept per REQ-020/021; no bubble.
- REQ-026: latency: accepted instruction appears at out_* 1 cycle after accept; a split instruction occupies the output for 2 consecutive consumed cycles (prefix then store) with the same out_pc.
- REQ-027: throughput: 1 pass-through/cycle; split-class instructions 1 per 2 cycles.
- REQ-028: flush has priority over all events: next state EMPTY, out_valid<=0, out_split<=0, hold registers discarded; in_ready=0 in the flush cycle so nothing is accepted.
- REQ-029: flush while in PRE drops both the prefix and the held store; neither is ever presented afterward.
- REQ-030: out_valid never deasserts without out_ready or flush; out_inst/out_pc/out_split stable while out_valid && !out_ready.

Reset
- REQ-031: rst_n low asynchronously forces state EMPTY, out_valid=0, out_split=0, out_inst=32'h0, out_pc=32'h0, hold registers=0.
- REQ-032: first accept possible on the first rising edge with rst_n high; reset mid-split discards the held store.

Verification
- REQ-033: sb x5,4(x2) (32'h00510223) pc=0x100, out_ready=1 -> cycle1 out_inst=div_res, out_split=1, pc=0x100; cycle2 out_inst=32'h00510223, out_split=0, pc=0x100; in_ready=0 in cycle1.
- REQ-034: stream of 4 add instructions, out_ready=1 -> one output per cycle, out_split=0, in_ready constantly 1, no bubbles.
- REQ-035: sh accepted, out_ready=0 for 3 cycles -> prefix held stable 3 cycles, then prefix and store each emitted once.
- REQ-036: sw (funct3=010) -> single pass-through output, out_split=0, div_res ignored.
- REQ-037: flush asserted in PRE -> next cycle out_valid=0, state EMPTY; store never appears; next accepted instruction emitted normally.
- REQ-038: rst_n pulled low while ORIG with out_valid=1 -> out_valid=0 immediately (asynchronously), outputs zero.
